// File: rtl/ro_meter_pkg.sv
// ro_meter_pkg
// Shared definitions for the ring-oscillator frequency meter: FSM state
// encoding, ARM phase length and helpers that derive the config register
// field layout from the channel count and gate-exponent width.
// Config layout (LSB first): channel select | gate exponent | mode.
package ro_meter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_GATE = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Cycles spent in ARM before the gate opens.
    localparam int ARM_LEN = 2;

    // Width of the channel-select field.
    function automatic int sel_w(input int n_ch);
        return (n_ch > 1) ? $clog2(n_ch) : 1;
    endfunction

    // Bit position of the gate-exponent LSB.
    function automatic int gexp_lsb(input int n_ch);
        return sel_w(n_ch);
    endfunction

    // Bit position of the mode bit (register MSB).
    function automatic int mode_bit(input int n_ch, input int gexp_w);
        return sel_w(n_ch) + gexp_w;
    endfunction

    // Total config register width.
    function automatic int cfg_w(input int n_ch, input int gexp_w);
        return sel_w(n_ch) + gexp_w + 1;
    endfunction

endpackage

// File: rtl/ro_sync_edge.sv
// ro_sync_edge
// Brings one asynchronous oscillator line into the clk domain through a
// two-flop synchroniser and emits a registered one-cycle pulse for every
// rising edge. An input edge shows up on pulse three clk edges later.
// Ports:
//   clk       reference clock
//   rst_n     asynchronous active-low reset
//   async_in  asynchronous oscillator input
//   pulse     one-cycle rising-edge pulse, clk domain
module ro_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic pulse
);

    logic meta_r;
    logic sync_r;
    logic prev_r;
    logic pulse_r;

    // Synchroniser chain, delayed copy and registered edge detect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_r  <= 1'b0;
            sync_r  <= 1'b0;
            prev_r  <= 1'b0;
            pulse_r <= 1'b0;
        end else begin
            meta_r  <= async_in;
            sync_r  <= meta_r;
            prev_r  <= sync_r;
            pulse_r <= sync_r & ~prev_r;
        end
    end

    assign pulse = pulse_r;

endmodule

// File: rtl/ro_freq_meter.sv
// ro_freq_meter
// Counts rising edges of one selected asynchronous oscillator over a gate
// window of 2^min(e, MAX_GEXP) reference cycles and latches the count.
// Configuration is shifted in serially; a shadow copy is taken during ARM,
// while the continuous/single decision at DONE uses the live mode bit so
// continuous runs can be stopped by shifting mode = 0.
// Ports:
//   clk, rst_n    reference clock, asynchronous active-low reset
//   osc_in        N_CH asynchronous oscillator inputs
//   cfg_shift_en  shift cfg_dta into config bit 0 this cycle
//   cfg_dta       serial config bit
//   start         one-cycle measurement request (ignored unless idle)
//   result        last latched count
//   valid         one-cycle pulse when result updates
//   busy          high outside IDLE
//   overflow      latched with result; count tried to pass all-ones
module ro_freq_meter
    import ro_meter_pkg::*;
#(
    parameter int N_CH     = 4,
    parameter int CNT_W    = 16,
    parameter int GEXP_W   = 5,
    parameter int MAX_GEXP = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_CH-1:0]  osc_in,
    input  logic             cfg_shift_en,
    input  logic             cfg_dta,
    input  logic             start,
    output logic [CNT_W-1:0] result,
    output logic             valid,
    output logic             busy,
    output logic             overflow
);

    localparam int SEL_W  = sel_w(N_CH);
    localparam int E_LSB  = gexp_lsb(N_CH);
    localparam int M_BIT  = mode_bit(N_CH, GEXP_W);
    localparam int CFG_W  = cfg_w(N_CH, GEXP_W);
    localparam int TMR_W  = MAX_GEXP + 1;
    localparam int ARM_W  = (ARM_LEN > 1) ? $clog2(ARM_LEN) : 1;

    logic [N_CH-1:0]   edge_s;
    logic [CFG_W-1:0]  cfg_r;
    state_t            state_r;
    state_t            state_s;
    logic [ARM_W-1:0]  arm_cnt_r;
    logic [SEL_W-1:0]  sel_r;
    logic [SEL_W-1:0]  sel_s;
    logic [TMR_W-1:0]  gate_last_r;
    logic [TMR_W-1:0]  gate_last_s;
    logic [GEXP_W-1:0] e_fld_s;
    logic [GEXP_W-1:0] e_clamp_s;
    logic [TMR_W-1:0]  timer_r;
    logic [CNT_W-1:0]  cnt_r;
    logic [CNT_W-1:0]  cnt_s;
    logic              ovf_r;
    logic              ovf_s;
    logic              edge_sel_s;
    logic [CNT_W-1:0]  result_r;
    logic              valid_r;
    logic              busy_r;
    logic              overflow_r;

    genvar g;
    generate
        for (g = 0; g < N_CH; g++) begin : g_sync
            ro_sync_edge u_sync (
                .clk      (clk),
                .rst_n    (rst_n),
                .async_in (osc_in[g]),
                .pulse    (edge_s[g])
            );
        end
    endgenerate

    // Decode the live config into the values captured by the ARM snapshot.
    always_comb begin
        sel_s       = '0;
        e_fld_s     = cfg_r[E_LSB +: GEXP_W];
        e_clamp_s   = e_fld_s;
        if (int'(cfg_r[SEL_W-1:0]) < N_CH) begin
            sel_s = cfg_r[SEL_W-1:0];
        end else begin
            sel_s = '0;
        end
        if (e_fld_s > GEXP_W'(MAX_GEXP)) begin
            e_clamp_s = GEXP_W'(MAX_GEXP);
        end else begin
            e_clamp_s = e_fld_s;
        end
        // Timer runs 0 .. 2^e-1, so store the terminal value.
        gate_last_s = (TMR_W'(1) << e_clamp_s) - TMR_W'(1);
    end

    // Saturating edge counter; overflow only on an increment past all-ones.
    always_comb begin
        edge_sel_s = edge_s[sel_r];
        cnt_s      = cnt_r;
        ovf_s      = ovf_r;
        if (edge_sel_s) begin
            if (cnt_r == {CNT_W{1'b1}}) begin
                ovf_s = 1'b1;
            end else begin
                cnt_s = cnt_r + CNT_W'(1);
            end
        end else begin
            cnt_s = cnt_r;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) state_s = ST_ARM;
                else       state_s = ST_IDLE;
            end
            ST_ARM: begin
                if (arm_cnt_r == ARM_W'(ARM_LEN - 1)) state_s = ST_GATE;
                else                                  state_s = ST_ARM;
            end
            ST_GATE: begin
                if (timer_r == gate_last_r) state_s = ST_DONE;
                else                        state_s = ST_GATE;
            end
            ST_DONE: begin
                if (cfg_r[M_BIT]) state_s = ST_ARM;
                else              state_s = ST_IDLE;
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Serial config shift register; legal in any state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_r <= '0;
        end else if (cfg_shift_en) begin
            cfg_r <= {cfg_r[CFG_W-2:0], cfg_dta};
        end
    end

    // FSM state, snapshot, gate timer, counter and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            arm_cnt_r   <= '0;
            sel_r       <= '0;
            gate_last_r <= '0;
            timer_r     <= '0;
            cnt_r       <= '0;
            ovf_r       <= 1'b0;
            result_r    <= '0;
            valid_r     <= 1'b0;
            busy_r      <= 1'b0;
            overflow_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            busy_r  <= (state_s != ST_IDLE);
            valid_r <= 1'b0;
            case (state_r)
                ST_ARM: begin
                    // Snapshot every ARM cycle so a shift coinciding with
                    // start is still picked up; edges here are discarded.
                    sel_r       <= sel_s;
                    gate_last_r <= gate_last_s;
                    timer_r     <= '0;
                    cnt_r       <= '0;
                    ovf_r       <= 1'b0;
                    if (state_s == ST_ARM) arm_cnt_r <= arm_cnt_r + ARM_W'(1);
                    else                   arm_cnt_r <= '0;
                end
                ST_GATE: begin
                    cnt_r   <= cnt_s;
                    ovf_r   <= ovf_s;
                    timer_r <= timer_r + TMR_W'(1);
                    // Load on the way into DONE so valid is seen during DONE,
                    // including any edge in the final gate cycle.
                    if (state_s == ST_DONE) begin
                        result_r   <= cnt_s;
                        overflow_r <= ovf_s;
                        valid_r    <= 1'b1;
                    end
                end
                default: begin
                    arm_cnt_r <= '0;
                end
            endcase
        end
    end

    assign result   = result_r;
    assign valid    = valid_r;
    assign busy     = busy_r;
    assign overflow = overflow_r;

endmodule

// File: tb/tb_ro_freq_meter.sv
// tb_ro_freq_meter
// Directed bench for ro_freq_meter. Two instances share all stimulus:
// dut_b (CNT_W=16, MAX_GEXP=20) and dut_s (CNT_W=4, MAX_GEXP=6), the latter
// making saturation and exponent clamping reachable in short runs.
// Free-running oscillators (changed on falling clk): ch0 period 16,
// ch1 period 4, ch2 period 8, ch3 held low. A manual override drives
// exact pulse trains on ch0 for the saturation corner cases.
module tb_ro_freq_meter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  osc_in;
    logic        cfg_shift_en;
    logic        cfg_dta;
    logic        start;
    logic [15:0] result_b;
    logic        valid_b, busy_b, ovf_b;
    logic [3:0]  result_s;
    logic        valid_s, busy_s, ovf_s;

    logic [3:0]  osc_gen = 4'b0000;
    logic [3:0]  osc_man;
    logic        use_man;
    int          ph [4] = '{default: 0};
    localparam int HALF [4] = '{8, 2, 4, 0};

    int n_checks = 0;
    int n_errors = 0;

    int          vcyc_b[$], vcyc_s[$];
    logic [15:0] vres_b[$];
    logic [3:0]  vres_s[$];
    logic        vovf_b[$], vovf_s[$];
    logic        busy_end_b, busy_end_s;

    typedef struct {
        logic [1:0] sel;
        logic [4:0] e;
        int         len_b;
        int         res_b;
        logic       ovf_b;
        int         len_s;
        int         res_s;
        logic       ovf_s;
    } vec_t;
    vec_t vecs [5];

    always #5 clk = ~clk;

    assign osc_in = use_man ? osc_man : osc_gen;

    // Free-running oscillator models, updated on falling clk.
    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (HALF[i] != 0) begin
                if (ph[i] == HALF[i] - 1) begin
                    ph[i]      <= 0;
                    osc_gen[i] <= ~osc_gen[i];
                end else begin
                    ph[i] <= ph[i] + 1;
                end
            end
        end
    end

    ro_freq_meter #(.N_CH(4), .CNT_W(16), .GEXP_W(5), .MAX_GEXP(20)) dut_b (
        .clk(clk), .rst_n(rst_n), .osc_in(osc_in), .cfg_shift_en(cfg_shift_en),
        .cfg_dta(cfg_dta), .start(start), .result(result_b), .valid(valid_b),
        .busy(busy_b), .overflow(ovf_b)
    );

    ro_freq_meter #(.N_CH(4), .CNT_W(4), .GEXP_W(5), .MAX_GEXP(6)) dut_s (
        .clk(clk), .rst_n(rst_n), .osc_in(osc_in), .cfg_shift_en(cfg_shift_en),
        .cfg_dta(cfg_dta), .start(start), .result(result_s), .valid(valid_s),
        .busy(busy_s), .overflow(ovf_s)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Shift an 8-bit config, MSB first so it lands in natural order.
    task automatic shift_cfg(input logic [7:0] val);
        for (int i = 7; i >= 0; i--) begin
            @(negedge clk);
            cfg_shift_en = 1'b1;
            cfg_dta      = val[i];
        end
        @(negedge clk);
        cfg_shift_en = 1'b0;
        cfg_dta      = 1'b0;
    endtask

    // Pulse start, then run ncyc cycles recording every valid of both DUTs.
    // Optional: a mid-run 8-bit config shift, a second start, and a manual
    // ch0 train of man_n pulses rising in cycles 3, 7, 11, ...
    task automatic measure(input int ncyc, input int shift_at, input logic [7:0] shift_val,
                           input int restart_at, input int man_n);
        vcyc_b.delete(); vres_b.delete(); vovf_b.delete();
        vcyc_s.delete(); vres_s.delete(); vovf_s.delete();
        @(negedge clk);
        start = 1'b1;
        for (int cyc = 1; cyc <= ncyc; cyc++) begin
            @(posedge clk);
            #1;
            start = (cyc == restart_at) ? 1'b1 : 1'b0;
            if (valid_b) begin
                vcyc_b.push_back(cyc); vres_b.push_back(result_b); vovf_b.push_back(ovf_b);
            end
            if (valid_s) begin
                vcyc_s.push_back(cyc); vres_s.push_back(result_s); vovf_s.push_back(ovf_s);
            end
            if (shift_at > 0 && cyc >= shift_at && cyc < shift_at + 8) begin
                cfg_shift_en = 1'b1;
                cfg_dta      = shift_val[7 - (cyc - shift_at)];
            end else begin
                cfg_shift_en = 1'b0;
                cfg_dta      = 1'b0;
            end
            if (man_n > 0 && cyc >= 3 && (cyc - 3) / 4 < man_n && (cyc - 3) % 4 < 2)
                osc_man = 4'b0001;
            else
                osc_man = 4'b0000;
        end
        busy_end_b = busy_b;
        busy_end_s = busy_s;
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        shift_cfg({1'b0, v.e, v.sel});
        measure(v.len_b + 5, 0, 8'h00, -1, 0);
        chk({tag, " b valid count"}, vcyc_b.size(), 1);
        chk({tag, " s valid count"}, vcyc_s.size(), 1);
        if (vcyc_b.size() > 0) begin
            chk({tag, " b valid cycle"}, vcyc_b[0], v.len_b);
            chk({tag, " b result"}, vres_b[0], v.res_b);
            chk({tag, " b overflow"}, vovf_b[0], v.ovf_b);
        end
        if (vcyc_s.size() > 0) begin
            chk({tag, " s valid cycle"}, vcyc_s[0], v.len_s);
            chk({tag, " s result"}, vres_s[0], v.res_s);
            chk({tag, " s overflow"}, vovf_s[0], v.ovf_s);
        end
        chk({tag, " b idle after"}, busy_end_b, 0);
        chk({tag, " s idle after"}, busy_end_s, 0);
    endtask

    initial begin
        // sel, e, len_b, res_b, ovf_b, len_s, res_s, ovf_s
        vecs[0] = '{2'd1, 5'd4, 19,  4, 1'b0, 19,  4, 1'b0};
        vecs[1] = '{2'd2, 5'd6, 67,  8, 1'b0, 67,  8, 1'b0};
        vecs[2] = '{2'd0, 5'd6, 67,  4, 1'b0, 67,  4, 1'b0};
        vecs[3] = '{2'd3, 5'd0,  4,  0, 1'b0,  4,  0, 1'b0};
        vecs[4] = '{2'd1, 5'd8, 259, 64, 1'b0, 67, 15, 1'b1};

        rst_n = 1'b0; start = 1'b0; cfg_shift_en = 1'b0; cfg_dta = 1'b0;
        use_man = 1'b0; osc_man = 4'b0000;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("reset result", result_b, 0);
        chk("reset valid", valid_b, 0);
        chk("reset busy", busy_b, 0);
        chk("reset overflow", ovf_b, 0);

        for (int i = 0; i < 5; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Continuous ch2/e=6, stopped by shifting mode=0 during the third window.
        shift_cfg(8'b1_00110_10);
        measure(205, 140, 8'b0_00110_10, -1, 0);
        chk("cont valid count", vcyc_b.size(), 3);
        for (int i = 0; i < vcyc_b.size() && i < 3; i++) begin
            chk($sformatf("cont valid%0d cycle", i), vcyc_b[i], 67 * (i + 1));
            chk($sformatf("cont valid%0d result", i), vres_b[i], 8);
        end
        chk("cont idle after stop", busy_end_b, 0);

        // Exact pulse trains on ch0, e=6: all-ones reached vs. exceeded.
        use_man = 1'b1;
        shift_cfg(8'b0_00110_00);
        measure(72, 0, 8'h00, -1, 15);
        chk("sat15 s result", (vres_s.size() > 0) ? vres_s[0] : 4'hx, 15);
        chk("sat15 s overflow", (vovf_s.size() > 0) ? vovf_s[0] : 1'bx, 0);
        chk("sat15 b result", (vres_b.size() > 0) ? vres_b[0] : 16'hxxxx, 15);
        measure(72, 0, 8'h00, -1, 16);
        chk("sat16 s result", (vres_s.size() > 0) ? vres_s[0] : 4'hx, 15);
        chk("sat16 s overflow", (vovf_s.size() > 0) ? vovf_s[0] : 1'bx, 1);
        chk("sat16 b result", (vres_b.size() > 0) ? vres_b[0] : 16'hxxxx, 16);
        chk("sat16 b overflow", (vovf_b.size() > 0) ? vovf_b[0] : 1'bx, 0);
        use_man = 1'b0;

        // e=31: dut_s clamps to 64 cycles, dut_b to 2^20; extra start ignored.
        shift_cfg(8'b0_11111_01);
        measure(120, 0, 8'h00, 30, 0);
        chk("e31 s valid count", vcyc_s.size(), 1);
        chk("e31 s valid cycle", (vcyc_s.size() > 0) ? vcyc_s[0] : 0, 67);
        chk("e31 s result", (vres_s.size() > 0) ? vres_s[0] : 4'hx, 15);
        chk("e31 s overflow", (vovf_s.size() > 0) ? vovf_s[0] : 1'bx, 1);
        chk("e31 b no valid", vcyc_b.size(), 0);
        chk("e31 b still busy", busy_end_b, 1);
        chk("e31 s idle", busy_end_s, 0);

        // Reset in the middle of dut_b's gate.
        rst_n = 1'b0;
        #1;
        chk("midrst b result", result_b, 0);
        chk("midrst b busy", busy_b, 0);
        chk("midrst b valid", valid_b, 0);
        chk("midrst s result", result_s, 0);
        chk("midrst s overflow", ovf_s, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        run_vec(vecs[0], "post-reset");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
